// File: rtl/temporal_lte_array.sv
// rtl/temporal_lte_array.sv - multi-channel gamma-cycle race-logic a<=b (or a<b) comparator
//
// Each channel watches the first arrival (first sampled high) of a[i] and b[i]
// inside a gamma cycle. If a wins (or ties with STRICT=0) the channel emits a
// PULSE_WIDTH-cycle pulse on q[i]; if b wins it raises the sticky inhibited[i].
// A free-running gamma counter returns every channel to IDLE on the last cycle
// of each gamma cycle, so no per-cycle external reset is needed.
//
// Optional build macro: TEMPORAL_LTE_TIMESTAMP_EN adds ts/ts_valid capture.
//
// Ports:
//   aclk        clock, rising edge
//   grst        synchronous active-high reset
//   a, b        per-channel race inputs
//   q           per-channel comparison pulse
//   inhibited   per-channel flag: b won this gamma cycle
//   gamma_start high while gcnt == 0
//   gamma_end   high while gcnt == GAMMA_CYCLE_LEN-1
//   ts          (macro only) per-channel gcnt of the firing sample, GW bits each
//   ts_valid    (macro only) per-channel ts-captured flag
module temporal_lte_array #(
    parameter int NUM_CH          = 8,
    parameter int PULSE_WIDTH     = 8,
    parameter int GAMMA_CYCLE_LEN = 16,
    parameter int STRICT          = 0
) (
    input  logic                      aclk,
    input  logic                      grst,
    input  logic [NUM_CH-1:0]         a,
    input  logic [NUM_CH-1:0]         b,
    output logic [NUM_CH-1:0]         q,
    output logic [NUM_CH-1:0]         inhibited,
    output logic                      gamma_start,
    output logic                      gamma_end
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
    ,
    output logic [NUM_CH*$clog2(GAMMA_CYCLE_LEN)-1:0] ts,
    output logic [NUM_CH-1:0]         ts_valid
`endif
);

    localparam int GW  = $clog2(GAMMA_CYCLE_LEN);
    localparam int PCW = $clog2(PULSE_WIDTH + 1);
    localparam logic [GW-1:0]  G_LAST = GW'(GAMMA_CYCLE_LEN - 1);
    localparam logic [PCW-1:0] P_MAX  = PCW'(PULSE_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PULSE   = 2'd1,
        S_DONE    = 2'd2,
        S_INHIBIT = 2'd3
    } state_t;

    logic [GW-1:0] r_gcnt;

    always_ff @(posedge aclk) begin
        if (grst) begin
            r_gcnt <= '0;
        end else if (r_gcnt == G_LAST) begin
            r_gcnt <= '0;
        end else begin
            r_gcnt <= r_gcnt + GW'(1);
        end
    end

    assign gamma_start = (r_gcnt == '0);
    assign gamma_end   = (r_gcnt == G_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t         r_state;
        state_t         w_state_nxt;
        logic [PCW-1:0] r_pcnt;
        logic [PCW-1:0] w_pcnt_nxt;
        logic           w_fire;

        always_comb begin
            w_state_nxt = r_state;
            w_pcnt_nxt  = r_pcnt;
            w_fire      = 1'b0;
            if (gamma_end) begin
                // Boundary wins over everything: truncates pulses and drops
                // whatever was sampled on this edge.
                w_state_nxt = S_IDLE;
                w_pcnt_nxt  = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (a[i] && !(b[i] && (STRICT != 0))) begin
                            w_state_nxt = S_PULSE;
                            w_pcnt_nxt  = PCW'(1);
                            w_fire      = 1'b1;
                        end else if (b[i]) begin
                            w_state_nxt = S_INHIBIT;
                        end
                    end
                    S_PULSE: begin
                        // pcnt counts the pulse cycle currently being shown.
                        if (r_pcnt >= P_MAX) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_pcnt_nxt = r_pcnt + PCW'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end

        always_ff @(posedge aclk) begin
            if (grst) begin
                r_state <= S_IDLE;
                r_pcnt  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_pcnt  <= w_pcnt_nxt;
            end
        end

        assign q[i]         = (r_state == S_PULSE);
        assign inhibited[i] = (r_state == S_INHIBIT);

`ifdef TEMPORAL_LTE_TIMESTAMP_EN
        logic [GW-1:0] r_ts;
        logic          r_ts_valid;

        always_ff @(posedge aclk) begin
            if (grst || gamma_end) begin
                r_ts       <= '0;
                r_ts_valid <= 1'b0;
            end else if (w_fire) begin
                r_ts       <= r_gcnt;
                r_ts_valid <= 1'b1;
            end
        end

        assign ts[i*GW +: GW] = r_ts;
        assign ts_valid[i]    = r_ts_valid;
`endif
    end

endmodule

// File: tb/tb_temporal_lte_array.sv
// tb/tb_temporal_lte_array.sv - randomized scoreboard bench for temporal_lte_array
module tb_temporal_lte_array;

    localparam int NUM_CH = 8;
    localparam int PW     = 8;
    localparam int L      = 16;
    localparam int STRICT = 0;
    localparam int GW     = $clog2(L);

    typedef struct packed {
        logic [NUM_CH-1:0] q;
        logic [NUM_CH-1:0] inh;
        logic              gs;
        logic              ge;
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
        logic [NUM_CH*GW-1:0] ts;
        logic [NUM_CH-1:0]    tsv;
`endif
    } exp_t;

    logic              aclk = 1'b0;
    logic              grst;
    logic [NUM_CH-1:0] a;
    logic [NUM_CH-1:0] b;
    logic [NUM_CH-1:0] q;
    logic [NUM_CH-1:0] inhibited;
    logic              gamma_start;
    logic              gamma_end;
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
    logic [NUM_CH*GW-1:0] ts;
    logic [NUM_CH-1:0]    ts_valid;
`endif

    temporal_lte_array #(
        .NUM_CH(NUM_CH), .PULSE_WIDTH(PW), .GAMMA_CYCLE_LEN(L), .STRICT(STRICT)
    ) dut (
        .aclk(aclk),
        .grst(grst),
        .a(a),
        .b(b),
        .q(q),
        .inhibited(inhibited),
        .gamma_start(gamma_start),
        .gamma_end(gamma_end)
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
        ,
        .ts(ts),
        .ts_valid(ts_valid)
`endif
    );

    always #5 aclk = ~aclk;

    exp_t sb[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic mon_en  = 1'b0;
    int   pa[NUM_CH];
    int   pb[NUM_CH];

    // Arrival t: line low before t, high at t, random afterwards (later
    // edges must be ignored). t < 0 means the line never rises.
    function automatic logic drv(input int t, input int k);
        if (t < 0 || k < t) return 1'b0;
        if (k == t) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // One gamma cycle driven from the arrival plan in pa/pb. Expected outputs
    // come straight from the race rule: an arrival on the last cycle is lost,
    // the earlier effective arrival wins, a tie goes to a unless STRICT.
    task automatic run_gamma(input int rst_at);
        for (int k = 0; k < L; k++) begin
            exp_t              e;
            logic [NUM_CH-1:0] av;
            logic [NUM_CH-1:0] bv;
            e = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                int  ta;
                int  tb;
                bit  fire;
                av[ch] = drv(pa[ch], k);
                bv[ch] = drv(pb[ch], k);
                ta = (pa[ch] >= 0 && pa[ch] <= L - 2) ? pa[ch] : -1;
                tb = (pb[ch] >= 0 && pb[ch] <= L - 2) ? pb[ch] : -1;
                fire = (ta >= 0) && (tb < 0 || ta < tb || (ta == tb && STRICT == 0));
                if (fire) begin
                    e.q[ch] = (k > ta) && (k <= ta + PW);
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
                    if (k > ta) begin
                        e.ts[ch*GW +: GW] = GW'(ta);
                        e.tsv[ch]         = 1'b1;
                    end
`endif
                end else if (tb >= 0) begin
                    e.inh[ch] = (k > tb);
                end
            end
            e.gs = (k == 0);
            e.ge = (k == L - 1);
            a    = av;
            b    = bv;
            grst = (k == rst_at);
            sb.push_back(e);
            @(posedge aclk);
            #1;
            if (k == rst_at) begin
                grst = 1'b0;
                break;
            end
        end
    endtask

    task automatic clear_plan();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pa[ch] = -1;
            pb[ch] = -1;
        end
    endtask

    task automatic random_plan();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pa[ch] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, L - 1));
            pb[ch] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, L - 1));
            if ($urandom_range(0, 5) == 0) pb[ch] = pa[ch];
        end
    endtask

    always @(negedge aclk) begin
        if (mon_en) begin
            cyc++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow cyc=%0d: no expected entry for output", cyc);
            end else begin
                m_e = sb.pop_front();
                if ({q, inhibited, gamma_start, gamma_end} !== {m_e.q, m_e.inh, m_e.gs, m_e.ge}) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d: got q=%h inh=%h gs=%b ge=%b, want q=%h inh=%h gs=%b ge=%b",
                             cyc, q, inhibited, gamma_start, gamma_end,
                             m_e.q, m_e.inh, m_e.gs, m_e.ge);
                end
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
                n_tests++;
                if ({ts, ts_valid} !== {m_e.ts, m_e.tsv}) begin
                    n_fail++;
                    $display("FAIL timestamp cyc=%0d: got ts=%h v=%h, want ts=%h v=%h",
                             cyc, ts, ts_valid, m_e.ts, m_e.tsv);
                end
`endif
            end
        end
    end

    initial begin
        grst = 1'b1;
        a    = '0;
        b    = '0;
        clear_plan();
        repeat (3) @(posedge aclk);
        #1;
        grst   = 1'b0;
        mon_en = 1'b1;

        // Directed gamma: a-first, b-first, tie, truncation at the boundary.
        pa[0] = 3;  pb[0] = 6;
        pa[1] = 5;  pb[1] = 2;
        pa[2] = 4;  pb[2] = 4;
        pa[3] = 12;
        pb[4] = 15;
        pa[5] = 15;
        run_gamma(-1);

        // Truncated channel fires again; late b never cancels.
        clear_plan();
        pa[3] = 1;  pb[3] = 2;
        pa[6] = 0;
        pa[7] = 14;
        run_gamma(-1);

        for (int g = 0; g < 40; g++) begin
            random_plan();
            run_gamma(-1);
        end

        // Reset on the third pulse cycle; next cycle must be a clean gcnt=0.
        random_plan();
        pa[0] = 0;  pb[0] = -1;
        run_gamma(3);
        random_plan();
        run_gamma(-1);

        mon_en = 1'b0;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
